fp_add_sched: RTL

Round-robin scheduler that shares one pipelined minifloat adder (the mantissa-align / add datapath of the fp adder) among `NUM_REQ` requesters in the LSTM accumulator. It accepts operand pairs over valid/ready handshakes and issues at most one add per cycle. A tag pipeline matched to the adder latency tracks every in-flight operation. Each result is routed into a one-deep per-requester response register, which the requester drains with its own handshake.

---
 rtl/fp_add_pkg.sv | 16 +
 rtl/fp_add_sched_rr_arbiter.sv | 36 +++
 rtl/fp_add_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the shared minifloat adder scheduler.
// Word layout: sign, 4-bit exponent, 3-bit stored mantissa (hidden bit implied).
package fp_add_pkg;
  localparam int DATA_W  = 8;
  localparam int EXP_W   = 4;
  localparam int MANT_W  = 4;
  localparam int MAX_REQ = 8;

  typedef logic [DATA_W-1:0] fp_word_t;
  typedef logic [$clog2(MAX_REQ)-1:0] rr_idx_t;

  // Index width for an n-way round-robin pointer, never narrower than 1 bit.
  function automatic int rr_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or above ptr, with wrap.
// Produces a one-hot grant (or all zero) plus the encoded grant index.
module rr_arbiter import fp_add_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = rr_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   gnt_idx
);
  localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k folded back into 0..NUM_REQ-1 without a divider
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= NUM_W) pos = pos - NUM_W;
      idx = pos[PTR_W-1:0];
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end
endmodule

// File: rtl/fp_add_sched.sv
// Shares one fixed-latency adder among NUM_REQ requesters: round-robin issue,
// a tag pipe aligned to the adder result, and a one-deep response slot per requester.
module fp_add_sched import fp_add_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = fp_add_pkg::DATA_W,
  parameter int ADD_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      add_valid,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W-1:0]         add_res,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      idle
);
  localparam int PTR_W = rr_idx_w(NUM_REQ);
  localparam int TAG_N = ADD_LAT + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TAG_N-1:0]          tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]          tag_idx_q [TAG_N];
  logic [PTR_W-1:0]          tag_idx_d [TAG_N];
  logic [DATA_W-1:0]         add_a_q, add_a_d, add_b_q, add_b_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] busy, eligible, grant, retire_oh;
  logic [PTR_W-1:0]   gnt_idx;
  logic               accept;

  // A requester stays busy from accept until its response is popped.
  always_comb begin
    busy = rsp_valid_q;
    for (int s = 0; s < TAG_N; s++)
      if (tag_vld_q[s]) busy[tag_idx_q[s]] = 1'b1;
  end

  assign eligible = req_valid & ~busy & {NUM_REQ{~rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign retire_oh = tag_vld_q[TAG_N-1] ? (NUM_REQ'(1) << tag_idx_q[TAG_N-1]) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    // stage 0 of the tag pipe is the issue register; the last stage lines up with add_res
    tag_vld_d    = {tag_vld_q[TAG_N-2:0], accept};
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < TAG_N; s++) tag_idx_d[s] = tag_idx_q[s-1];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        add_a_d = req_a[i*DATA_W +: DATA_W];
        add_b_d = req_b[i*DATA_W +: DATA_W];
      end
    end
    if (accept) rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);

    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | retire_oh;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (retire_oh[i]) rsp_data_d[i*DATA_W +: DATA_W] = add_res;
  end

  // issue / tag / response register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk) tag_idx_q <= tag_idx_d;

  assign add_valid = tag_vld_q[0];
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = ~|tag_vld_q & ~|rsp_valid_q;
endmodule
